// File: rtl/sha_core_arbiter.sv
// -----------------------------------------------------------------------------
// sha_core_arbiter
//
// Shares one SHA-256 core between NUM_REQ hash requesters with a registered
// round-robin arbiter. For each hash it latches the winner's message block,
// pulses sha_init, waits for the core digest, hands it back to the winner with
// a one-cycle done pulse, then soft-resets the core before the next grant.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   req                per-requester level request
//   req_block          requester i block at [i*BLOCK_W +: BLOCK_W]
//   gnt                one-hot grant, high from ISSUE through WAIT_DONE
//   done               one-cycle pulse to the granted requester
//   digest             last returned digest, held until the next done
//   digest_err         qualifies done: digest invalid (watchdog expired)
//   busy               arbiter not idle
//   sha_init           one-cycle start pulse to the core
//   sha_reset_n        active-low soft reset to the core
//   sha_block          latched message block to the core
//   sha_ready          core ready
//   sha_digest         core digest
//   sha_digest_valid   core digest valid
//
// Build option:
//   SHA_ARB_TIMEOUT_EN  adds a WAIT watchdog of TIMEOUT_CYCLES cycles that
//                       ends the hash with done + digest_err. Without it WAIT
//                       holds until the core answers and digest_err stays 0.
// -----------------------------------------------------------------------------
module sha_core_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int BLOCK_W        = 512,
   parameter int DIGEST_W       = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic [DIGEST_W-1:0]          digest,
   output logic                         digest_err,
   output logic                         busy,
   output logic                         sha_init,
   output logic                         sha_reset_n,
   output logic [BLOCK_W-1:0]           sha_block,
   input  logic                         sha_ready,
   input  logic [DIGEST_W-1:0]          sha_digest,
   input  logic                         sha_digest_valid
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CAND_W = PTR_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WAIT_DONE,
      ST_CORE_RST
   } state_e;

   state_e               state_q,       state_d;
   logic [PTR_W-1:0]     rr_ptr_q,      rr_ptr_d;
   logic [PTR_W-1:0]     g_idx_q,       g_idx_d;
   logic [NUM_REQ-1:0]   gnt_q,         gnt_d;
   logic [NUM_REQ-1:0]   done_q,        done_d;
   logic [DIGEST_W-1:0]  digest_q,      digest_d;
   logic                 digest_err_q,  digest_err_d;
   logic                 busy_q,        busy_d;
   logic                 sha_init_q,    sha_init_d;
   logic                 sha_reset_n_q, sha_reset_n_d;
   logic [BLOCK_W-1:0]   sha_block_q,   sha_block_d;

   logic                 win_found;
   logic [PTR_W-1:0]     win_idx;
   logic [CAND_W-1:0]    cand;
   logic                 timeout_hit;

   // --------------------------------------------------------------------------
   // Round-robin winner search. Offsets are walked from farthest to nearest so
   // the requester closest to rr_ptr (inclusive) is the last, winning, match.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + CAND_W'(k);
         if (cand >= CAND_W'(NUM_REQ)) begin
            cand = cand - CAND_W'(NUM_REQ);
         end
         if (req[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   // --------------------------------------------------------------------------
   // WAIT watchdog
   // --------------------------------------------------------------------------
`ifdef SHA_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == ST_ISSUE) begin
         to_cnt_d = '0;
      end else if (state_q == ST_WAIT) begin
         to_cnt_d = to_cnt_q + 16'd1;
      end
   end

   // Fires on the WAIT cycle in which the count steps onto TIMEOUT_CYCLES-1,
   // so done lands TIMEOUT_CYCLES cycles after the ISSUE cycle.
   assign timeout_hit = (state_q == ST_WAIT) &&
                        (to_cnt_d == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   // Watchdog compiled out: WAIT holds until the core answers. TIMEOUT_CYCLES
   // has no effect in this build.
   assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   // --------------------------------------------------------------------------
   // Next-state and registered-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      g_idx_d       = g_idx_q;
      gnt_d         = gnt_q;
      done_d        = '0;
      digest_d      = digest_q;
      digest_err_d  = digest_err_q;
      sha_init_d    = 1'b0;
      sha_reset_n_d = sha_reset_n_q;
      sha_block_d   = sha_block_q;

      unique case (state_q)
         ST_IDLE: begin
            sha_reset_n_d = 1'b1;
            // A stale digest_valid from the previous hash must clear first.
            if (win_found && sha_ready && !sha_digest_valid) begin
               g_idx_d          = win_idx;
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
               sha_block_d      = req_block[win_idx*BLOCK_W +: BLOCK_W];
               sha_init_d       = 1'b1;
               state_d          = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sha_digest_valid) begin
               digest_d     = sha_digest;
               digest_err_d = 1'b0;
               done_d       = gnt_q;
               state_d      = ST_WAIT_DONE;
            end else if (timeout_hit) begin
               digest_err_d = 1'b1;
               done_d       = gnt_q;
               state_d      = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            gnt_d         = '0;
            sha_reset_n_d = 1'b0;
            rr_ptr_d      = (g_idx_q == PTR_W'(NUM_REQ - 1)) ? '0
                                                             : g_idx_q + PTR_W'(1);
            state_d       = ST_CORE_RST;
         end
         ST_CORE_RST: begin
            sha_reset_n_d = 1'b1;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the block and digest registers are reset too: downstream logic
      // may look at sha_block/digest before the first hash, so they must not
      // power up as X.
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         g_idx_q       <= '0;
         gnt_q         <= '0;
         done_q        <= '0;
         digest_q      <= '0;
         digest_err_q  <= 1'b0;
         busy_q        <= 1'b0;
         sha_init_q    <= 1'b0;
         sha_reset_n_q <= 1'b0;
         sha_block_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values, independent of statement order.
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         g_idx_q       <= g_idx_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         digest_q      <= digest_d;
         digest_err_q  <= digest_err_d;
         busy_q        <= busy_d;
         sha_init_q    <= sha_init_d;
         sha_reset_n_q <= sha_reset_n_d;
         sha_block_q   <= sha_block_d;
      end
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign digest      = digest_q;
   assign digest_err  = digest_err_q;
   assign busy        = busy_q;
   assign sha_init    = sha_init_q;
   assign sha_reset_n = sha_reset_n_q;
   assign sha_block   = sha_block_q;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha_core_arbiter
//
// Self-checking bench for sha_core_arbiter. The bench plays the SHA core and
// the requesters; a round-robin reference model (pointer + modular search)
// predicts every grant. Inputs are driven and outputs sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha_core_arbiter;

   localparam int NUM_REQ        = 2;
   localparam int BLOCK_W        = 512;
   localparam int DIGEST_W       = 256;
   localparam int TIMEOUT_CYCLES = 16;
`ifdef SHA_ARB_TIMEOUT_EN
   localparam int SINGLE_LAT     = 10;
`else
   localparam int SINGLE_LAT     = 64;
`endif

   logic                         clk = 1'b0;
   logic                         reset_n;
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*BLOCK_W-1:0]   req_block;
   logic [NUM_REQ-1:0]           gnt;
   logic [NUM_REQ-1:0]           done;
   logic [DIGEST_W-1:0]          digest;
   logic                         digest_err;
   logic                         busy;
   logic                         sha_init;
   logic                         sha_reset_n;
   logic [BLOCK_W-1:0]           sha_block;
   logic                         sha_ready;
   logic [DIGEST_W-1:0]          sha_digest;
   logic                         sha_digest_valid;

   int n_checks = 0;
   int n_pass   = 0;
   int model_ptr = 0;
   logic [DIGEST_W-1:0] last_dig = '0;

   always #5 clk = ~clk;

   sha_core_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .BLOCK_W        (BLOCK_W),
      .DIGEST_W       (DIGEST_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req              (req),
      .req_block        (req_block),
      .gnt              (gnt),
      .done             (done),
      .digest           (digest),
      .digest_err       (digest_err),
      .busy             (busy),
      .sha_init         (sha_init),
      .sha_reset_n      (sha_reset_n),
      .sha_block        (sha_block),
      .sha_ready        (sha_ready),
      .sha_digest       (sha_digest),
      .sha_digest_valid (sha_digest_valid)
   );

   // ---------------------------------------------------------------- model ---
   function automatic logic [BLOCK_W-1:0] rand_block();
      logic [BLOCK_W-1:0] b;
      for (int i = 0; i < BLOCK_W / 32; i++) b[i*32 +: 32] = $urandom();
      return b;
   endfunction

   function automatic logic [DIGEST_W-1:0] rand_digest();
      logic [DIGEST_W-1:0] d;
      for (int i = 0; i < DIGEST_W / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   // Round-robin rule: first asserted request at ptr, ptr+1, ... mod NUM_REQ.
   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // ------------------------------------------------------------- helpers ---
   task automatic wait_gnt(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (gnt == '0 && cyc < 200);
   endtask

   // Core answers after lat cycles with a one-cycle digest_valid; returns on
   // the falling edge where done is visible.
   task automatic serve(input int lat, input logic [DIGEST_W-1:0] d);
      repeat (lat) @(negedge clk);
      sha_digest       = d;
      sha_digest_valid = 1'b1;
      @(negedge clk);
      sha_digest_valid = 1'b0;
      sha_digest       = rand_digest();
      last_dig         = d;
   endtask

   // --------------------------------------------------------------- tests ---
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (gnt !== '0) $display("FAIL reset_gnt: got %b want 0", gnt); else n_pass++;
      n_checks++; if (done !== '0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_checks++; if (digest !== '0) $display("FAIL reset_digest: got %h want 0", digest); else n_pass++;
      n_checks++; if (digest_err !== 1'b0) $display("FAIL reset_err: got %b want 0", digest_err); else n_pass++;
      n_checks++; if (sha_init !== 1'b0) $display("FAIL reset_init: got %b want 0", sha_init); else n_pass++;
      n_checks++; if (sha_reset_n !== 1'b0) $display("FAIL reset_core_rst: got %b want 0", sha_reset_n); else n_pass++;
      n_checks++; if (sha_block !== '0) $display("FAIL reset_block: got %h want 0", sha_block); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++; if (sha_reset_n !== 1'b1) $display("FAIL idle_core_rst: got %b want 1", sha_reset_n); else n_pass++;
      model_ptr = 0;
   endtask

   task automatic test_single();
      logic [BLOCK_W-1:0]  blk;
      logic [DIGEST_W-1:0] d;
      blk = rand_block();
      d   = rand_digest();
      req_block[0 +: BLOCK_W] = blk;
      req = 2'b01;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else n_pass++;
      n_checks++; if (sha_init !== 1'b1) $display("FAIL single_init: got %b want 1", sha_init); else n_pass++;
      n_checks++; if (sha_block !== blk) $display("FAIL single_block: got %h want %h", sha_block, blk); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
      req_block[0 +: BLOCK_W] = rand_block();
      @(negedge clk);
      n_checks++; if (sha_init !== 1'b0) $display("FAIL single_init_pulse: got %b want 0", sha_init); else n_pass++;
      serve(SINGLE_LAT - 1, d);
      n_checks++; if (done !== 2'b01) $display("FAIL single_done: got %b want 01", done); else n_pass++;
      n_checks++; if (digest !== d) $display("FAIL single_digest: got %h want %h", digest, d); else n_pass++;
      n_checks++; if (digest_err !== 1'b0) $display("FAIL single_err: got %b want 0", digest_err); else n_pass++;
      n_checks++; if (sha_block !== blk) $display("FAIL single_block_held: got %h want %h", sha_block, blk); else n_pass++;
      req = '0;
      @(negedge clk);
      n_checks++; if (done !== '0) $display("FAIL single_done_pulse: got %b want 0", done); else n_pass++;
      n_checks++; if (sha_reset_n !== 1'b0) $display("FAIL single_core_rst: got %b want 0", sha_reset_n); else n_pass++;
      n_checks++; if (gnt !== '0) $display("FAIL single_gnt_clear: got %b want 0", gnt); else n_pass++;
      n_checks++; if (digest !== d) $display("FAIL single_digest_hold: got %h want %h", digest, d); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
      n_checks++; if (sha_reset_n !== 1'b1) $display("FAIL single_core_rel: got %b want 1", sha_reset_n); else n_pass++;
      @(negedge clk);
      n_checks++; if (gnt !== '0) $display("FAIL single_no_req: got %b want 0", gnt); else n_pass++;
      model_ptr = 1;
   endtask

   // Fixed full contention (rand_mode=0) or random request patterns.
   task automatic test_round_robin(input int n_hash, input bit rand_mode);
      logic [BLOCK_W-1:0]  blk [NUM_REQ];
      logic [DIGEST_W-1:0] d;
      logic [NUM_REQ-1:0]  r;
      int exp_w, cyc, lat;
      for (int h = 0; h < n_hash; h++) begin
         r = rand_mode ? NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)) : '1;
         for (int i = 0; i < NUM_REQ; i++) begin
            blk[i] = rand_block();
            req_block[i*BLOCK_W +: BLOCK_W] = blk[i];
         end
         req   = r;
         exp_w = rr_pick(r, model_ptr);
         wait_gnt(cyc);
         n_checks++; if (cyc !== 1) $display("FAIL rr_latency[%0d]: got %0d cycles want 1", h, cyc); else n_pass++;
         n_checks++; if (gnt !== onehot(exp_w)) $display("FAIL rr_gnt[%0d]: got %b want %b", h, gnt, onehot(exp_w)); else n_pass++;
         n_checks++; if (sha_block !== blk[exp_w]) $display("FAIL rr_block[%0d]: got %h want %h", h, sha_block, blk[exp_w]); else n_pass++;
         d   = rand_digest();
         lat = $urandom_range(1, 12);
         if (rand_mode) req = NUM_REQ'($urandom());
         serve(lat, d);
         n_checks++; if (done !== onehot(exp_w)) $display("FAIL rr_done[%0d]: got %b want %b", h, done, onehot(exp_w)); else n_pass++;
         n_checks++; if (digest !== d) $display("FAIL rr_digest[%0d]: got %h want %h", h, digest, d); else n_pass++;
         @(negedge clk);
         @(negedge clk);
         n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle[%0d]: got %b want 0", h, busy); else n_pass++;
         model_ptr = (exp_w + 1) % NUM_REQ;
      end
      req = '0;
   endtask

   task automatic test_withdraw();
      logic [DIGEST_W-1:0] d;
      int cyc;
      sha_ready = 1'b0;
      req = 2'b01;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (gnt !== '0) $display("FAIL stall_not_ready[%0d]: got %b want 0", i, gnt); else n_pass++;
      end
      req = '0;
      @(negedge clk);
      sha_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (gnt !== '0) $display("FAIL withdrawn[%0d]: got %b want 0", i, gnt); else n_pass++;
      end
      // Late drop: the hash still completes.
      req = 2'b01;
      wait_gnt(cyc);
      n_checks++; if (gnt !== 2'b01) $display("FAIL late_gnt: got %b want 01", gnt); else n_pass++;
      @(negedge clk);
      req = '0;
      d = rand_digest();
      serve(5, d);
      n_checks++; if (done !== 2'b01) $display("FAIL late_done: got %b want 01", done); else n_pass++;
      n_checks++; if (digest !== d) $display("FAIL late_digest: got %h want %h", digest, d); else n_pass++;
      repeat (2) @(negedge clk);
      model_ptr = 1;
   endtask

   task automatic test_core_busy();
      logic [BLOCK_W-1:0]  blk;
      logic [DIGEST_W-1:0] d;
      int cyc, exp_w;
      blk = rand_block();
      req_block[1*BLOCK_W +: BLOCK_W] = blk;
      sha_digest_valid = 1'b1;
      req = 2'b10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (gnt !== '0) $display("FAIL stale_valid[%0d]: got %b want 0", i, gnt); else n_pass++;
      end
      sha_digest_valid = 1'b0;
      sha_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++; if (gnt !== '0) $display("FAIL busy_not_ready[%0d]: got %b want 0", i, gnt); else n_pass++;
      end
      sha_ready = 1'b1;
      exp_w = rr_pick(2'b10, model_ptr);
      wait_gnt(cyc);
      n_checks++; if (cyc !== 1) $display("FAIL busy_release_latency: got %0d cycles want 1", cyc); else n_pass++;
      n_checks++; if (gnt !== onehot(exp_w)) $display("FAIL busy_release_gnt: got %b want %b", gnt, onehot(exp_w)); else n_pass++;
      n_checks++; if (sha_block !== blk) $display("FAIL busy_release_block: got %h want %h", sha_block, blk); else n_pass++;
      req = '0;
      d = rand_digest();
      serve(3, d);
      n_checks++; if (done !== onehot(exp_w)) $display("FAIL busy_done: got %b want %b", done, onehot(exp_w)); else n_pass++;
      repeat (2) @(negedge clk);
      model_ptr = (exp_w + 1) % NUM_REQ;
   endtask

   task automatic test_mid_reset();
      logic [DIGEST_W-1:0] d;
      int cyc;
      req = 2'b01;
      wait_gnt(cyc);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++; if (gnt !== '0) $display("FAIL mrst_gnt: got %b want 0", gnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (sha_reset_n !== 1'b0) $display("FAIL mrst_core_rst: got %b want 0", sha_reset_n); else n_pass++;
      n_checks++; if (sha_block !== '0) $display("FAIL mrst_block: got %h want 0", sha_block); else n_pass++;
      n_checks++; if (digest !== '0) $display("FAIL mrst_digest: got %h want 0", digest); else n_pass++;
      // A digest arriving while reset is held must not produce done.
      sha_digest       = rand_digest();
      sha_digest_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (done !== '0) $display("FAIL mrst_no_done[%0d]: got %b want 0", i, done); else n_pass++;
      end
      sha_digest_valid = 1'b0;
      reset_n   = 1'b1;
      model_ptr = 0;
      req = 2'b11;
      wait_gnt(cyc);
      n_checks++; if (gnt !== onehot(rr_pick(2'b11, model_ptr))) $display("FAIL mrst_regrant: got %b want %b", gnt, onehot(rr_pick(2'b11, model_ptr))); else n_pass++;
      req = '0;
      d = rand_digest();
      serve(2, d);
      n_checks++; if (done !== 2'b01) $display("FAIL mrst_done: got %b want 01", done); else n_pass++;
      repeat (2) @(negedge clk);
      model_ptr = 1;
   endtask

   task automatic test_timeout();
      int cyc, exp_w;
      bit seen_done;
      logic [DIGEST_W-1:0] d;
      exp_w = rr_pick(2'b01, model_ptr);
      req = 2'b01;
      wait_gnt(cyc);
      n_checks++; if (gnt !== onehot(exp_w)) $display("FAIL to_gnt: got %b want %b", gnt, onehot(exp_w)); else n_pass++;
      req = '0;
`ifdef SHA_ARB_TIMEOUT_EN
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (done == '0 && cyc < 64);
      n_checks++; if (cyc !== TIMEOUT_CYCLES) $display("FAIL to_latency: got %0d cycles want %0d", cyc, TIMEOUT_CYCLES); else n_pass++;
      n_checks++; if (done !== onehot(exp_w)) $display("FAIL to_done: got %b want %b", done, onehot(exp_w)); else n_pass++;
      n_checks++; if (digest_err !== 1'b1) $display("FAIL to_err: got %b want 1", digest_err); else n_pass++;
      n_checks++; if (digest !== last_dig) $display("FAIL to_digest_held: got %h want %h", digest, last_dig); else n_pass++;
      @(negedge clk);
      n_checks++; if (sha_reset_n !== 1'b0) $display("FAIL to_core_rst: got %b want 0", sha_reset_n); else n_pass++;
      @(negedge clk);
      model_ptr = (exp_w + 1) % NUM_REQ;
`else
      seen_done = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (done != '0) seen_done = 1'b1;
      end
      n_checks++; if (seen_done !== 1'b0) $display("FAIL no_to_done: got %b want 0", seen_done); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL no_to_busy: got %b want 1", busy); else n_pass++;
      d = rand_digest();
      serve(1, d);
      n_checks++; if (done !== onehot(exp_w)) $display("FAIL no_to_done_late: got %b want %b", done, onehot(exp_w)); else n_pass++;
      n_checks++; if (digest !== d) $display("FAIL no_to_digest: got %h want %h", digest, d); else n_pass++;
      repeat (2) @(negedge clk);
      model_ptr = (exp_w + 1) % NUM_REQ;
`endif
   endtask

   // ---------------------------------------------------------------- main ---
   initial begin
      reset_n          = 1'b0;
      req              = '0;
      req_block        = '0;
      sha_ready        = 1'b1;
      sha_digest       = '0;
      sha_digest_valid = 1'b0;
      test_reset();
      test_single();
      test_round_robin(4, 1'b0);
      test_withdraw();
      test_core_busy();
      test_mid_reset();
      test_timeout();
      test_round_robin(20, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/sha_core_arbiter.md
Name: sha_core_arbiter

Overview:
Sequences and shares one SHA-256 core between NUM_REQ hash requesters, such as several hash_drbg instances for the scrambler and descrambler paths. It replaces ad-hoc tri-state bus sharing with a registered round-robin arbiter. For each hash it latches the winner's 512-bit block, issues the init pulse, waits for the digest, returns it to the winner, then resets the core between hashes.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BLOCK_W, 512, message block width
DIGEST_W, 256, digest width
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (only with SHA_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
req  in  NUM_REQ  per-requester hash request, level
req_block  in  NUM_REQ*BLOCK_W  requester i block at [i*BLOCK_W +: BLOCK_W]
gnt  out  NUM_REQ  one-hot grant, high from ISSUE through WAIT_DONE
done  out  NUM_REQ  one-cycle pulse to the granted requester, digest valid
digest  out  DIGEST_W  last digest, held until next done
digest_err  out  1  qualifies done: digest invalid (timeout)
busy  out  1  state != IDLE
sha_init  out  1  to core, one-cycle start pulse
sha_reset_n  out  1  to core, active-low soft reset
sha_block  out  BLOCK_W  to core, latched block
sha_ready  in  1  core ready
sha_digest  in  DIGEST_W  core digest
sha_digest_valid  in  1  core digest valid

Behaviour:
- Reset values: gnt=0, done=0, digest=0, digest_err=0, sha_init=0, sha_reset_n=0, sha_block=0, state=IDLE, rr_ptr=0.
- Reset is asynchronous and may arrive mid-hash. It aborts the transaction with no done pulse; requesters re-request after reset.
- FSM states: IDLE, ISSUE, WAIT, WAIT_DONE, CORE_RST. All outputs are registered.
- IDLE, entry: sha_reset_n=1.
  - Grant condition: |req && sha_ready && !sha_digest_valid.
  - Winner: first asserted req at index rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On grant: latch req_block[winner] into sha_block, set gnt[winner], go to ISSUE.
- ISSUE: sha_init=1 for exactly this cycle, then go to WAIT.
- WAIT: on sha_digest_valid, latch sha_digest into digest, pulse done[g] with digest_err=0, go to WAIT_DONE.
- WAIT_DONE: gnt cleared, sha_reset_n=0 for one cycle, rr_ptr = g+1 mod NUM_REQ, go to CORE_RST.
- CORE_RST: sha_reset_n=1, go to IDLE.
- Latency:
  - req sampled at cycle N gives gnt and sha_init high at N+1.
  - digest_valid at cycle M gives done/digest at M+1.
  - Earliest next grant is at M+4.
- Request rules:
  - req must stay high until done. The block is latched at grant, so the requester may change req_block afterwards.
  - req dropped before grant withdraws the request.
  - req dropped after grant is ignored; the hash completes and done still pulses.
  - req still high after done counts as a new request and competes in round-robin.
- Simultaneous requests are resolved by rr_ptr. No requester waits more than NUM_REQ-1 hashes.
- sha_digest_valid outside WAIT is ignored; IDLE waits for it to clear.
- sha_ready low in IDLE stalls the grant.

Optional Feature:
Macro SHA_ARB_TIMEOUT_EN.
- With it: a 16-bit counter clears on ISSUE and increments in WAIT. When it reaches TIMEOUT_CYCLES-1, the block pulses done[g] with digest_err=1, keeps digest unchanged, and goes to WAIT_DONE (core reset, pointer advances).
- Without it: WAIT holds indefinitely and digest_err is tied to 0.

Test Plan:
- Single request: req=2'b01, block=A, core returns D after 64 cycles -> gnt=01 and sha_init at N+1, sha_block=A, done=01 one cycle with digest=D, sha_reset_n low one cycle, busy low at M+3.
- Contention: req=2'b11 held -> grant order 0,1,0,1 over four hashes, each done matching its gnt; rr_ptr wraps 1->0.
- Withdrawal and late drop: req0 dropped while core not ready -> no grant. req0 dropped during WAIT -> done[0] still pulses.
- Core busy: sha_ready=0, or sha_digest_valid=1 held in IDLE -> no gnt until ready=1 and valid=0.
- Mid-hash reset: reset_n low in WAIT -> all outputs return to reset values, no done; after release req0 is regranted from rr_ptr=0.
- Timeout (with SHA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no digest_valid -> done[g] with digest_err=1 at ISSUE+16, digest unchanged. Without the macro the block stays in WAIT.
